mnist_train_sequencer: RTL

- Sequences training and evaluation for the ten-class pseudo-linear MNIST array of ten one-vs-rest learners.
- Fetches samples from an external sample memory over a req/ack handshake and presents one shared 794-bit image word to all learners.
- Drives per-class target bits and a single-cycle learn strobe, decodes the ten learner outputs into a predicted class, and accumulates per-epoch error statistics.

---
 rtl/mnist_train_sequencer.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mnist_train_sequencer.sv
// Training/evaluation sequencer for the ten one-vs-rest MNIST learners: fetches samples,
// drives targets and the learn strobe, decodes predictions and keeps per-epoch error counts.
module mnist_train_sequencer #(
    parameter int N_SAMPLES = 1000,
    parameter int N_EPOCHS  = 8,
    parameter int ADDR_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              train_mode,
    input  logic              abort,
    input  logic [3:0]        threshold_cfg,
    output logic [3:0]        threshold,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [783:0]      mem_pixels,
    input  logic [3:0]        mem_label,
    output logic [793:0]      img_out,
    output logic [9:0]        target,
    output logic              learn_en,
    input  logic [9:0]        class_result,
    output logic [3:0]        pred_class,
    output logic              busy,
    output logic              done,
    output logic [7:0]        epoch,
    output logic [15:0]       err_count,
    output logic [15:0]       last_epoch_err,
    output logic [15:0]       skip_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SETTLE,
        S_UPDATE,
        S_NEXT,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [7:0]        LAST_EPOCH = 8'(N_EPOCHS - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_train;
    logic [3:0]          r_threshold;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_epoch;
    logic [15:0]         r_err;
    logic [15:0]         r_last_err;
    logic [15:0]         r_skip;
    logic [3:0]          r_pred;
    logic [793:0]        r_img;
    logic [9:0]          r_target;

    logic [3:0]          w_pred;
    logic                w_label_ok;
    logic                w_last_addr;
    logic                w_last_epoch;

    // Lowest set learner output wins; no output set means "no prediction".
    always_comb begin
        w_pred = 4'hF;
        for (int i = 9; i >= 0; i--) begin
            if (class_result[i]) begin
                w_pred = 4'(i);
            end
        end
    end

    assign w_label_ok   = (mem_label <= 4'd9);
    assign w_last_addr  = (r_addr == LAST_ADDR);
    assign w_last_epoch = (r_epoch >= LAST_EPOCH);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_next = S_FETCH;
            S_FETCH:  if (mem_ack) w_state_next = w_label_ok ? S_SETTLE : S_NEXT;
            S_SETTLE: w_state_next = r_train ? S_UPDATE : S_NEXT;
            S_UPDATE: w_state_next = S_NEXT;
            S_NEXT: begin
                if (!w_last_addr || (r_train && !w_last_epoch)) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
        if (abort) begin
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Abort freezes every counter and register in the cycle it is seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_train     <= 1'b0;
            r_threshold <= 4'd0;
            r_addr      <= '0;
            r_epoch     <= 8'd0;
            r_err       <= 16'd0;
            r_last_err  <= 16'd0;
            r_skip      <= 16'd0;
            r_pred      <= 4'hF;
            r_img       <= '0;
            r_target    <= 10'd0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_train     <= train_mode;
                        r_threshold <= threshold_cfg;
                        r_addr      <= '0;
                        r_epoch     <= 8'd0;
                        r_err       <= 16'd0;
                        r_skip      <= 16'd0;
                        r_pred      <= 4'hF;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_img    <= {mem_pixels, 6'd0, mem_label};
                        r_target <= w_label_ok ? (10'd1 << mem_label) : 10'd0;
                        if (!w_label_ok && (r_skip != 16'hFFFF)) begin
                            r_skip <= r_skip + 16'd1;
                        end
                    end
                end
                S_SETTLE: begin
                    r_pred <= w_pred;
                    if ((w_pred != r_img[3:0]) && (r_err != 16'hFFFF)) begin
                        r_err <= r_err + 16'd1;
                    end
                end
                S_NEXT: begin
                    if (!w_last_addr) begin
                        r_addr <= r_addr + 1'b1;
                    end else begin
                        r_last_err <= r_err;
                        r_err      <= 16'd0;
                        r_addr     <= '0;
                        if (r_train && !w_last_epoch) begin
                            r_epoch <= r_epoch + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req        = (r_state == S_FETCH) && !abort;
    assign learn_en       = (r_state == S_UPDATE);
    assign busy           = (r_state != S_IDLE);
    assign done           = (r_state == S_DONE);
    assign mem_addr       = r_addr;
    assign threshold      = r_threshold;
    assign img_out        = r_img;
    assign target         = r_target;
    assign pred_class     = r_pred;
    assign epoch          = r_epoch;
    assign err_count      = r_err;
    assign last_epoch_err = r_last_err;
    assign skip_count     = r_skip;

endmodule
